gfx_dma_queue: RTL and testbench
================================

// Module: gfx_dma_queue
// PURPOSE
//  Blit-descriptor queue sitting directly upstream of the GFX DMA register port.
//  The CPU stages 8 descriptor bytes (src lo/hi, dst lo/hi, width, height, mask, start/mode).
//  Writing byte 7 commits the descriptor into a FIFO. A dispatcher replays each queued
//  descriptor into the DMA register bus (addr 0..7) once the DMA is idle, so the CPU
//  can queue several blits without polling.
// PARAMETERS
//  DEPTH          4    descriptor FIFO depth (power of 2, >=2)
//  WE_CYCLES      2    clk cycles o_dma_we_b is held low per register write (>=1)
//  ACK_TIMEOUT    64   clk cycles to wait for i_dma_active after a start write
// PORTS
//  i_clk        in   1   system clock (all logic rising-edge)
//  i_rst        in   1   synchronous reset, active-high
//  i_ce_b       in   1   CPU chip enable, active low
//  i_we_b       in   1   CPU write strobe, active low (synchronous to i_clk)
//  i_addr       in   4   0..7 staging bytes, 8 control
//  i_data       in   8   CPU write data
//  o_dma_ce_b   out  1   DMA register chip enable, active low
//  o_dma_we_b   out  1   DMA register write strobe, active low
//  o_dma_addr   out  3   DMA register index
//  o_dma_data   out  8   DMA register data
//  i_dma_active in   1   DMA busy (high while a blit runs)
//  o_level      out  $clog2(DEPTH)+1  queued descriptors (excludes in-flight)
//  o_empty/o_full out 1  FIFO flags
//  o_busy       out  1   dispatcher not IDLE
//  o_overflow   out  1   sticky: commit attempted while full
//  o_timeout    out  1   sticky: DMA never went active after a start write
// BEHAVIOUR
//  Reset: ce_b=1, we_b=1, addr=0, data=0, level=0, empty=1, full=0, busy=0,
//   overflow=0, timeout=0. Staging regs and FIFO are cleared. FSM goes to IDLE.
//   Reset mid-dispatch aborts the dispatch; ce_b/we_b go high on the same edge.
//  CPU write accepted on the cycle i_ce_b=0 and i_we_b rises: low last cycle, high now.
//   One accept per strobe.
//  addr 0..7: staging[addr] <= i_data. addr 7 additionally pushes {staging[0..6], i_data}
//   to the FIFO.
//  addr 8: bit0=1 clears overflow and timeout. bit1=1 flushes queued entries;
//   an in-flight descriptor still completes.
//  Push when full: dropped, overflow<=1, level unchanged. Push and pop on the same cycle:
//   both occur and level is unchanged. A push on a flush cycle is discarded.
//  FIFO pointers wrap modulo DEPTH. full = level==DEPTH. Level width is $clog2(DEPTH)+1.
//  FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (next byte SETUP | WAIT_ACK) -> WAIT_DONE.
//   IDLE: if !empty && !i_dma_active, latch head descriptor, pop it, byte=0, go to SETUP next cycle.
//   SETUP (1 cyc): ce_b=0, we_b=1, addr=byte, data=desc[byte].
//   STROBE (WE_CYCLES cyc): we_b=0; addr and data stable.
//   HOLD (1 cyc): we_b=1, addr and data stable. byte==7 -> WAIT_ACK, else byte+1 -> SETUP.
//   ce_b stays 0 from the first SETUP through the last HOLD, then returns to 1.
//   WAIT_ACK: on i_dma_active=1 go to WAIT_DONE. After ACK_TIMEOUT cycles without it,
//    set timeout=1 and go to IDLE.
//   WAIT_DONE: on i_dma_active=0 go to IDLE.
//  Descriptor load is 8*(WE_CYCLES+2) cycles (32 at default). IDLE-to-first-SETUP latency is 1 cycle.
//  busy = state!=IDLE. Descriptor bytes are passed through unmodified; this block does no arithmetic on them.
// TESTING
//  1 Stage {00,00,10,10,05,05,FF,00}, commit -> level 0->1->0.
//    8 writes addr 0..7 with that data, each we_b low exactly 2 cycles.
//    Hold i_dma_active=1 for 100 cycles -> busy=1 until it drops, then IDLE.
//  2 Commit 5 descriptors with i_dma_active held 1 -> full after 4, overflow=1 on 5th, level=4.
//    Write addr8=01 -> overflow=0.
//  3 Two queued descriptors, DMA pulses active 50 cycles each.
//    -> second load starts 1 cycle after active falls; descriptor order preserved.
//  4 Start write with i_dma_active never rising -> timeout=1 after 64 cycles, FSM IDLE,
//    next descriptor dispatched.
//  5 Assert i_rst during STROBE of byte 3 -> ce_b=1, we_b=1 next edge, level=0, no further writes.
//  6 Flush (addr8=02) during dispatch with 2 queued -> in-flight completes, level=0,
//    no further loads.

Source files
------------

// File: rtl/gfx_dma_queue.sv
// gfx_dma_queue: CPU-staged blit descriptor FIFO replayed onto the DMA register port
module gfx_dma_queue #(
    parameter int DEPTH = 4,
    parameter int WE_CYCLES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ce_b,
    input  logic                   i_we_b,
    input  logic [3:0]             i_addr,
    input  logic [7:0]             i_data,
    output logic                   o_dma_ce_b,
    output logic                   o_dma_we_b,
    output logic [2:0]             o_dma_addr,
    output logic [7:0]             o_dma_data,
    input  logic                   i_dma_active,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_busy,
    output logic                   o_overflow,
    output logic                   o_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT + WE_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_ACK, WAIT_DONE} state_t;
    state_t state, state_n;
    logic we_b_q;
    logic [7:0] staging [8];
    logic [63:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [63:0] desc;
    logic [2:0] idx;
    logic [CW-1:0] cnt;
    logic overflow, timeout;
    logic accept, push, push_ok, flush, clr, pop, tmo_hit;
    assign accept = !i_ce_b && i_we_b && !we_b_q;
    assign push = accept && i_addr == 4'd7;
    assign push_ok = push && !o_full;
    assign flush = accept && i_addr == 4'd8 && i_data[1];
    assign clr = accept && i_addr == 4'd8 && i_data[0];
    assign pop = state == IDLE && !o_empty && !i_dma_active;
    assign tmo_hit = state == WAIT_ACK && !i_dma_active && cnt == CW'(ACK_TIMEOUT - 1);
    assign o_level = level;
    assign o_empty = level == '0;
    assign o_full = level == (AW+1)'(DEPTH);
    assign o_busy = state != IDLE;
    assign o_overflow = overflow;
    assign o_timeout = timeout;
    assign o_dma_ce_b = !(state inside {SETUP, STROBE, HOLD});
    assign o_dma_we_b = state != STROBE;
    assign o_dma_addr = idx;
    assign o_dma_data = desc[{idx, 3'b000} +: 8];
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = pop ? SETUP : IDLE;
            SETUP:     state_n = STROBE;
            STROBE:    state_n = cnt == CW'(WE_CYCLES - 1) ? HOLD : STROBE;
            HOLD:      state_n = idx == 3'd7 ? WAIT_ACK : SETUP;
            WAIT_ACK:  state_n = i_dma_active ? WAIT_DONE : (tmo_hit ? IDLE : WAIT_ACK);
            WAIT_DONE: state_n = i_dma_active ? WAIT_DONE : IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            we_b_q <= 1'b1;
            for (int i = 0; i < 8; i++) staging[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            desc <= '0;
            idx <= '0;
            cnt <= '0;
            overflow <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            we_b_q <= i_we_b;
            cnt <= state_n != state ? '0 : cnt + 1'b1;
            if (accept && !i_addr[3]) staging[i_addr[2:0]] <= i_data;
            if (push_ok) begin
                mem[wr_ptr] <= {i_data, staging[6], staging[5], staging[4],
                                staging[3], staging[2], staging[1], staging[0]};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                level <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) begin
                desc <= mem[rd_ptr];
                idx <= '0;
            end else if (state == HOLD && idx != 3'd7) begin
                idx <= idx + 1'b1;
            end
            overflow <= (overflow && !clr) || (push && o_full);
            timeout <= (timeout && !clr) || tmo_hit;
        end
    end
endmodule

// File: tb/tb_gfx_dma_queue.sv
// tb_gfx_dma_queue: directed checks of descriptor queueing, DMA replay timing and sticky flags
module tb_gfx_dma_queue;
    logic clk = 1'b0;
    logic rst, ce_b, we_b, dma_active;
    logic [3:0] addr;
    logic [7:0] data;
    logic dma_ce_b, dma_we_b, empty, full, busy, overflow, timeout;
    logic [2:0] dma_addr;
    logic [7:0] dma_data;
    logic [2:0] level;
    int n_vec = 0;
    int n_err = 0;
    logic [23:0] wr_q[$];
    logic [7:0] lo_cnt = '0;
    logic [2:0] lo_addr = '0;
    logic [7:0] lo_data = '0;

    gfx_dma_queue dut (
        .i_clk(clk), .i_rst(rst), .i_ce_b(ce_b), .i_we_b(we_b), .i_addr(addr), .i_data(data),
        .o_dma_ce_b(dma_ce_b), .o_dma_we_b(dma_we_b), .o_dma_addr(dma_addr), .o_dma_data(dma_data),
        .i_dma_active(dma_active), .o_level(level), .o_empty(empty), .o_full(full),
        .o_busy(busy), .o_overflow(overflow), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!dma_we_b) begin
            lo_cnt <= lo_cnt + 1'b1;
            lo_addr <= dma_addr;
            lo_data <= dma_data;
        end else if (lo_cnt != 0) begin
            wr_q.push_back({lo_cnt, 5'b0, lo_addr, lo_data});
            lo_cnt <= '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ce_b = 1'b0; we_b = 1'b0; addr = a; data = d;
        @(negedge clk);
        we_b = 1'b1;
        @(negedge clk);
        ce_b = 1'b1;
    endtask

    task automatic commit(input logic [63:0] d);
        for (int i = 0; i < 8; i++) cpu_wr(4'(i), d[i*8 +: 8]);
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_q.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("wait_wr", 64'(wr_q.size() >= n), 64'd1);
    endtask

    task automatic check_load(input logic [63:0] d);
        logic [23:0] e;
        wait_writes(8);
        for (int i = 0; i < 8; i++) begin
            e = wr_q.size() != 0 ? wr_q.pop_front() : '0;
            chk($sformatf("load_b%0d", i), 64'(e), 64'({8'd2, 5'b0, 3'(i), d[i*8 +: 8]}));
        end
    endtask

    task automatic pulse_active(input int n);
        @(negedge clk);
        dma_active = 1'b1;
        repeat (n) @(negedge clk);
        dma_active = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [63:0] d1, da, db, dc, dd;
        d1 = 64'h00FF0505_10100000;
        da = 64'h88776655_44332211;
        db = 64'h01F0E0D0_C0B0A090;
        dc = 64'h1234ABCD_5A5AC3C3;
        dd = 64'h0F1E2D3C_4B5A6978;
        rst = 1'b1; ce_b = 1'b1; we_b = 1'b1; addr = '0; data = '0; dma_active = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ce_b", 64'(dma_ce_b), 64'd1);
        chk("rst_we_b", 64'(dma_we_b), 64'd1);
        chk("rst_addr", 64'(dma_addr), 64'd0);
        chk("rst_data", 64'(dma_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_flags", 64'({empty, full, busy, overflow, timeout}), 64'b10000);

        for (int i = 0; i < 7; i++) cpu_wr(4'(i), d1[i*8 +: 8]);
        chk("t1_level_staged", 64'(level), 64'd0);
        cpu_wr(4'd7, d1[63:56]);
        chk("t1_level_commit", 64'(level), 64'd1);
        @(negedge clk);
        chk("t1_level_pop", 64'(level), 64'd0);
        chk("t1_setup", 64'({busy, dma_ce_b, dma_we_b, dma_addr}), 64'({1'b1, 1'b0, 1'b1, 3'd0}));
        check_load(d1);
        pulse_active(100);
        chk("t1_busy_active", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_idle", 64'(busy), 64'd0);

        @(negedge clk);
        dma_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            commit(da ^ 64'(i));
            chk($sformatf("t2_level%0d", i + 1), 64'(level), 64'(i + 1));
        end
        chk("t2_full", 64'(full), 64'd1);
        commit(db);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_level_keep", 64'(level), 64'd4);
        cpu_wr(4'd8, 8'h01);
        chk("t2_ovf_clr", 64'(overflow), 64'd0);
        cpu_wr(4'd8, 8'h02);
        chk("t2_flush", 64'({level, empty}), 64'({3'd0, 1'b1}));
        dma_active = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_no_load", 64'(wr_q.size()), 64'd0);

        dma_active = 1'b1;
        commit(da);
        commit(db);
        chk("t3_level", 64'(level), 64'd2);
        dma_active = 1'b0;
        check_load(da);
        pulse_active(50);
        @(negedge clk);
        chk("t3_gap", 64'({busy, dma_ce_b}), 64'b01);
        @(negedge clk);
        chk("t3_restart", 64'({busy, dma_ce_b, dma_addr}), 64'({1'b1, 1'b0, 3'd0}));
        check_load(db);
        pulse_active(50);
        repeat (2) @(negedge clk);
        chk("t3_done", 64'({busy, level}), 64'd0);

        dma_active = 1'b1;
        commit(dc);
        commit(dd);
        dma_active = 1'b0;
        check_load(dc);
        repeat (64) @(negedge clk);
        chk("t4_pre_timeout", 64'({timeout, busy}), 64'b01);
        @(negedge clk);
        chk("t4_timeout", 64'({timeout, busy}), 64'b10);
        @(negedge clk);
        chk("t4_next", 64'({dma_ce_b, level}), 64'd0);
        check_load(dd);
        pulse_active(3);
        repeat (3) @(negedge clk);
        chk("t4_idle", 64'(busy), 64'd0);
        cpu_wr(4'd8, 8'h01);
        chk("t4_tmo_clr", 64'(timeout), 64'd0);

        dma_active = 1'b1;
        commit(da);
        commit(db);
        dma_active = 1'b0;
        wait_writes(3);
        @(negedge clk);
        chk("t5_setup_b3", 64'({dma_ce_b, dma_we_b, dma_addr}), 64'({1'b0, 1'b1, 3'd3}));
        @(negedge clk);
        chk("t5_strobe_b3", 64'(dma_we_b), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_strobes", 64'({dma_ce_b, dma_we_b}), 64'b11);
        chk("t5_rst_state", 64'({level, busy}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        wr_q.delete();
        repeat (60) @(negedge clk);
        chk("t5_no_writes", 64'(wr_q.size()), 64'd0);

        dma_active = 1'b1;
        commit(dc);
        commit(dd);
        commit(da);
        chk("t6_level", 64'(level), 64'd3);
        dma_active = 1'b0;
        wait_writes(2);
        cpu_wr(4'd8, 8'h02);
        chk("t6_flush", 64'(level), 64'd0);
        check_load(dc);
        pulse_active(20);
        repeat (60) @(negedge clk);
        chk("t6_no_more", 64'(wr_q.size()), 64'd0);
        chk("t6_idle", 64'({busy, level, empty}), 64'({1'b0, 3'd0, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
